// File: rtl/sha256_compress.sv
// sha256_compress: SHA-256 compression engine, one round per accepted schedule word
module sha256_compress #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] h_in,
    input  logic         w_valid,
    input  logic [31:0]  w_data,
    output logic         w_ready,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    state_t state, state_n;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] s0, s1, ch, maj, t1, t2;
    logic [255:0] hsave;
    logic [5:0] t;
    logic hs;
    assign s1  = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
    assign s0  = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
    assign ch  = (e & f) ^ (~e & g);
    assign maj = (a & b) ^ (a & c) ^ (b & c);
    assign t1  = h + s1 + ch + K[t] + w_data;
    assign t2  = s0 + maj;
    always_comb begin
        w_ready = state == ROUND;
        busy    = state != IDLE;
        hs      = w_ready & w_valid;
        state_n = (state == IDLE && start)        ? ROUND :
                  (hs && t == 6'(ROUNDS - 1))     ? FINAL :
                  (state == FINAL)                ? IDLE  : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            t      <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
            hsave  <= '0;
            done   <= 1'b0;
            digest <= '0;
        end else begin
            state <= state_n;
            done  <= state == FINAL;
            if (state == IDLE && start) begin
                hsave <= h_in;
                {a, b, c, d, e, f, g, h} <= h_in;
                t <= '0;
            end
            if (hs) begin
                {a, b, c, d, e, f, g, h} <= {t1 + t2, a, b, c, d + t1, e, f, g};
                t <= t + 6'd1;
            end
            // Feed-forward: chaining value plus working state, word by word
            if (state == FINAL)
                digest <= {hsave[255:224] + a, hsave[223:192] + b, hsave[191:160] + c, hsave[159:128] + d,
                           hsave[127:96]  + e, hsave[95:64]   + f, hsave[63:32]   + g, hsave[31:0]    + h};
        end
    end
endmodule

// File: tb/tb_sha256_compress.sv
// tb_sha256_compress: randomized self-checking bench with a FIPS 180-4 reference model
module tb_sha256_compress;
    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sched_t [64];
    localparam logic [255:0] H_INIT  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk = 0, rst = 0, start = 0, w_valid = 0;
    logic [255:0] h_in = '0;
    logic [31:0] w_data = '0;
    logic w_ready, busy, done;
    logic [255:0] digest;
    int n_cmp = 0, n_err = 0;
    logic [31:0] kk [64];

    sha256_compress #(.ROUNDS(64)) dut (
        .clk(clk), .rst(rst), .start(start), .h_in(h_in), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready), .busy(busy), .done(done), .digest(digest)
    );

    always #5 clk = ~clk;

    // Round constants: first 32 fraction bits of the cube roots of the first 64 primes
    function automatic void init_k();
        int p, n;
        bit prime;
        real r;
        p = 2;
        n = 0;
        while (n < 64) begin
            prime = 1;
            for (int q = 2; q * q <= p; q++) if (p % q == 0) prime = 0;
            if (prime) begin
                r = $pow(real'(p), 1.0 / 3.0);
                kk[n] = 32'(longint'($floor((r - $floor(r)) * 4294967296.0)));
                n++;
            end
            p++;
        end
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic void expand(input blk_t m, output sched_t w);
        for (int i = 0; i < 64; i++)
            w[i] = (i < 16) ? m[i] :
                   w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) +
                   w[i-7] + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input sched_t w);
        logic [31:0] v [8];
        logic [31:0] hv [8];
        logic [31:0] x1, x2;
        logic [255:0] res;
        for (int i = 0; i < 8; i++) begin
            hv[i] = hin[255 - 32*i -: 32];
            v[i] = hv[i];
        end
        for (int r = 0; r < 64; r++) begin
            x1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
                 ((v[4] & v[5]) ^ (~v[4] & v[6])) + kk[r] + w[r];
            x2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
                 ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + x1;
            v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hv[i] + v[i];
        return res;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drives one block from the current cycle; counts protocol anomalies seen along the way
    task automatic run_block(input logic [255:0] h, input sched_t w, input int max_stall, input int poke_t,
                             input int abort_t, output logic [255:0] dig, output int edges,
                             output int nready, output int nbusy, output int ndone);
        int stall;
        nready = 0; nbusy = 0; ndone = 0;
        start = 1; h_in = h; w_valid = 0;
        @(posedge clk); #1;
        start = 0; h_in = rnd256(); edges = 1;
        if (!busy) nbusy++;
        if (done) ndone++;
        for (int idx = 0; idx < 64; idx++) begin
            if (idx == abort_t) begin
                rst = 1; w_valid = 1; w_data = w[idx];
                @(posedge clk); #1;
                rst = 0; w_valid = 0; edges++;
                dig = digest;
                return;
            end
            stall = max_stall > 0 ? int'($urandom_range(max_stall, 0)) : 0;
            repeat (stall) begin
                w_valid = 0; w_data = $urandom();
                @(posedge clk); #1;
                edges++;
                if (!busy) nbusy++;
                if (done) ndone++;
                if (!w_ready) nready++;
            end
            w_valid = 1; w_data = w[idx];
            if (!w_ready) nready++;
            if (idx == poke_t) begin start = 1; h_in = rnd256(); end
            @(posedge clk); #1;
            edges++; start = 0; w_valid = 0;
            if (!busy) nbusy++;
            if (done) ndone++;
        end
        if (w_ready) nready++;
        @(posedge clk); #1;
        edges++;
        if (!done) ndone++;
        dig = digest;
    endtask

    function automatic void empty_sched(output sched_t w);
        blk_t m = '{default: 32'h0};
        m[0] = 32'h80000000;
        expand(m, w);
    endfunction

    function automatic void abc_sched(output sched_t w);
        blk_t m = '{default: 32'h0};
        m[0] = 32'h61626380;
        m[15] = 32'h00000018;
        expand(m, w);
    endfunction

    task automatic test_reset();
        rst = 1; start = 1; w_valid = 1; h_in = rnd256(); w_data = $urandom();
        repeat (2) @(posedge clk);
        #1;
        rst = 0; start = 0; w_valid = 0;
        n_cmp += 4;
        if (digest !== '0) begin n_err++; $display("FAIL reset_digest: got %h expected 0", digest); end
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        if (w_ready !== 1'b0) begin n_err++; $display("FAIL reset_w_ready: got %b expected 0", w_ready); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_empty();
        sched_t w;
        logic [255:0] dig;
        int edges, nr, nb, nd;
        int idle_rdy = 0;
        w_valid = 1;
        repeat (4) begin
            w_data = $urandom();
            @(posedge clk); #1;
            if (w_ready !== 1'b0) idle_rdy++;
        end
        w_valid = 0;
        empty_sched(w);
        run_block(H_INIT, w, 0, -1, -1, dig, edges, nr, nb, nd);
        n_cmp += 5;
        if (idle_rdy != 0) begin n_err++; $display("FAIL empty_idle_ready: got %0d cycles with w_ready expected 0", idle_rdy); end
        if (dig !== D_EMPTY) begin n_err++; $display("FAIL empty_digest: got %h expected %h", dig, D_EMPTY); end
        if (edges != 66) begin n_err++; $display("FAIL empty_latency: got %0d edges expected 66", edges); end
        if (nr + nb != 0) begin n_err++; $display("FAIL empty_handshake: got %0d ready/busy faults expected 0", nr + nb); end
        if (nd != 0) begin n_err++; $display("FAIL empty_done_timing: got %0d done faults expected 0", nd); end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL empty_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_abc();
        sched_t w;
        logic [255:0] dig;
        int edges, nr, nb, nd;
        abc_sched(w);
        run_block(H_INIT, w, 0, -1, -1, dig, edges, nr, nb, nd);
        n_cmp += 3;
        if (dig !== D_ABC) begin n_err++; $display("FAIL abc_digest: got %h expected %h", dig, D_ABC); end
        if (edges != 66) begin n_err++; $display("FAIL abc_latency: got %0d edges expected 66", edges); end
        if (nr + nb + nd != 0) begin n_err++; $display("FAIL abc_protocol: got %0d faults expected 0", nr + nb + nd); end
    endtask

    task automatic test_stalls();
        sched_t w;
        logic [255:0] dig;
        int edges, nr, nb, nd;
        abc_sched(w);
        run_block(H_INIT, w, 5, -1, -1, dig, edges, nr, nb, nd);
        n_cmp += 4;
        if (dig !== D_ABC) begin n_err++; $display("FAIL stall_digest: got %h expected %h", dig, D_ABC); end
        if (nb != 0) begin n_err++; $display("FAIL stall_busy: got %0d busy-low cycles expected 0", nb); end
        if (nd != 0) begin n_err++; $display("FAIL stall_done_timing: got %0d done faults expected 0", nd); end
        if (nr != 0) begin n_err++; $display("FAIL stall_ready: got %0d ready faults expected 0", nr); end
    endtask

    task automatic test_start_ignored();
        sched_t w;
        logic [255:0] dig;
        int edges, nr, nb, nd;
        abc_sched(w);
        run_block(H_INIT, w, 0, 20, -1, dig, edges, nr, nb, nd);
        n_cmp += 2;
        if (dig !== D_ABC) begin n_err++; $display("FAIL start_ignored_digest: got %h expected %h", dig, D_ABC); end
        if (edges != 66) begin n_err++; $display("FAIL start_ignored_latency: got %0d edges expected 66", edges); end
    endtask

    task automatic test_reset_mid();
        sched_t w;
        logic [255:0] dig;
        int edges, nr, nb, nd;
        abc_sched(w);
        run_block(H_INIT, w, 0, -1, 30, dig, edges, nr, nb, nd);
        n_cmp += 4;
        if (dig !== '0) begin n_err++; $display("FAIL midreset_digest: got %h expected 0", dig); end
        if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b expected 0", done); end
        if (w_ready !== 1'b0) begin n_err++; $display("FAIL midreset_w_ready: got %b expected 0", w_ready); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        run_block(H_INIT, w, 0, -1, -1, dig, edges, nr, nb, nd);
        n_cmp++;
        if (dig !== D_ABC) begin n_err++; $display("FAIL midreset_rerun_digest: got %h expected %h", dig, D_ABC); end
    endtask

    task automatic test_back_to_back();
        blk_t m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
                     32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_t m2 = '{default: 32'h0};
        sched_t w1, w2;
        logic [255:0] d1, d2;
        int e1, e2, nr, nb, nd;
        m2[15] = 32'h000001c0;
        expand(m1, w1);
        expand(m2, w2);
        run_block(H_INIT, w1, 0, -1, -1, d1, e1, nr, nb, nd);
        n_cmp++;
        if (done !== 1'b1) begin n_err++; $display("FAIL chain_done_cycle: got %b expected 1", done); end
        run_block(d1, w2, 0, -1, -1, d2, e2, nr, nb, nd);
        n_cmp += 2;
        if (d2 !== D_TWO) begin n_err++; $display("FAIL chain_digest: got %h expected %h", d2, D_TWO); end
        if (e2 != 66) begin n_err++; $display("FAIL chain_latency: got %0d edges expected 66", e2); end
    endtask

    task automatic test_random();
        blk_t m;
        sched_t w;
        logic [255:0] h, dig, exp_d;
        int edges, nr, nb, nd;
        for (int it = 0; it < 6; it++) begin
            h = rnd256();
            for (int i = 0; i < 16; i++) m[i] = $urandom();
            expand(m, w);
            exp_d = ref_compress(h, w);
            run_block(h, w, 2, -1, -1, dig, edges, nr, nb, nd);
            n_cmp += 2;
            if (dig !== exp_d) begin n_err++; $display("FAIL random_digest[%0d]: got %h expected %h", it, dig, exp_d); end
            if (nr + nb + nd != 0) begin n_err++; $display("FAIL random_protocol[%0d]: got %0d faults expected 0", it, nr + nb + nd); end
        end
    endtask

    initial begin
        init_k();
        #1;
        test_reset();
        test_empty();
        test_abc();
        test_stalls();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
